// File: rtl/yadro_gen_pkg.sv
// yadro_gen_pkg: shared FSM states, LFSR mask and corner-set indices for the operand generator
package yadro_gen_pkg;
    typedef enum logic [1:0] {IDLE, GEN, OFFER, DONE} state_t;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam int MAG_BITS = 17;
    localparam int CORNER_ZERO = 0;
    localparam int CORNER_POS = 1;
    localparam int CORNER_NEG = 2;
    localparam int CORNER_ALT = 3;
    localparam int NUM_CORNERS = 4;
endpackage

// File: rtl/yadro_operand_gen_if.sv
// yadro_operand_gen_if: valid/ready operand bus carrying the signed a..d set
interface yadro_operand_gen_if #(parameter int WIDTH = 32);
    logic out_valid;
    logic out_ready;
    logic signed [WIDTH-1:0] a, b, c, d;
    modport master (output out_valid, a, b, c, d, input out_ready);
    modport slave (input out_valid, a, b, c, d, output out_ready);
endinterface

// File: rtl/yadro_lfsr32.sv
// yadro_lfsr32: 32-bit Galois LFSR, steps when en is high; a zero seed is replaced by 1
module yadro_lfsr32
    import yadro_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] state
);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= (seed == '0) ? 32'd1 : seed;
        else if (en) state <= state[0] ? ((state >> 1) ^ LFSR_MASK) : (state >> 1);
endmodule

// File: rtl/yadro_operand_gen.sv
// yadro_operand_gen: repeatable random operand source for the test_yadro datapath
// Optional OPGEN_CORNER_EN prepends four fixed corner sets to every run.
module yadro_operand_gen
    import yadro_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM_VECTORS = 100,
    parameter int MAG_MAX = 99999,
    parameter logic [31:0] SEED = 32'h1ACE_B00C,
    localparam int CW = $clog2(NUM_VECTORS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         vec_cnt,
    yadro_operand_gen_if.master   bus
);
    state_t state;
    logic [1:0] op_idx;
    logic [WIDTH-1:0] ops [4];
    logic valid;
    logic [31:0] lfsr;
    logic [MAG_BITS-1:0] mag;
    logic [WIDTH-1:0] pos, draw;
    logic take, en, last;
    logic unused_lfsr;
    assign mag = lfsr[MAG_BITS-1:0];
    assign pos = WIDTH'(mag);
    assign unused_lfsr = ^lfsr[31:MAG_BITS+1];
    assign last = 32'(vec_cnt) + 1 == NUM_VECTORS;
`ifdef OPGEN_CORNER_EN
    localparam logic [WIDTH-1:0] MPOS = WIDTH'(MAG_MAX);
    logic [31:0] set_idx;
    logic corner;
    logic [WIDTH-1:0] corner_val;
    assign set_idx = 32'(vec_cnt);
    assign corner = set_idx < NUM_CORNERS;
    assign corner_val = set_idx == CORNER_ZERO ? '0 :
                        set_idx == CORNER_POS  ? MPOS :
                        set_idx == CORNER_NEG  ? -MPOS :
                        op_idx[0]              ? -MPOS : MPOS;
    assign draw = corner ? corner_val : (lfsr[MAG_BITS] ? -pos : pos);
    assign take = corner || 32'(mag) <= MAG_MAX;
    assign en = state == GEN && !corner;
`else
    assign draw = lfsr[MAG_BITS] ? -pos : pos;
    assign take = 32'(mag) <= MAG_MAX;
    assign en = state == GEN;
`endif
    yadro_lfsr32 u_lfsr (.clk(clk), .rst(rst), .en(en), .seed(SEED), .state(lfsr));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            op_idx <= '0;
            ops <= '{default: '0};
            valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            vec_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= GEN;
                    vec_cnt <= '0;
                    op_idx <= '0;
                    done <= 1'b0;
                    busy <= 1'b1;
                end
                GEN: if (take) begin
                    ops[op_idx] <= draw;
                    op_idx <= op_idx + 2'd1;
                    if (op_idx == 2'd3) begin
                        state <= OFFER;
                        valid <= 1'b1;
                    end
                end
                OFFER: if (bus.out_ready) begin
                    vec_cnt <= vec_cnt + CW'(1);
                    valid <= 1'b0;
                    if (last) begin
                        state <= DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        state <= GEN;
                        op_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    assign bus.out_valid = valid;
    assign bus.a = ops[0];
    assign bus.b = ops[1];
    assign bus.c = ops[2];
    assign bus.d = ops[3];
endmodule

// File: tb/tb_yadro_operand_gen.sv
// tb_yadro_operand_gen: scoreboard bench against a queue-based model of the operand sequence
module tb_yadro_operand_gen;
    localparam int NV = 100;
    localparam int MM = 99999;
    localparam logic [31:0] SEED_V = 32'h1;
    localparam logic [31:0] MASK = 32'h8020_0003;
    logic clk = 0;
    logic rst = 1;
    logic start = 0;
    logic busy, done;
    logic [6:0] vec_cnt;
    yadro_operand_gen_if #(.WIDTH(32)) bus ();
    yadro_operand_gen #(.WIDTH(32), .NUM_VECTORS(NV), .MAG_MAX(MM), .SEED(SEED_V)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .vec_cnt(vec_cnt), .bus(bus)
    );
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    logic [127:0] q[$];
    logic [127:0] got[$];
    logic [31:0] ml;
    logic [127:0] held, cur, save_a, b_first;
    bit stalled = 0;
    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic bit in_range(logic signed [31:0] v);
        return v >= -MM && v <= MM;
    endfunction
    function automatic logic [31:0] step(logic [31:0] x);
        return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
    endfunction
    // each run's expected sets are drawn from the model LFSR, which carries over between runs
    task automatic push_run();
        for (int n = 0; n < NV; n++) begin
            int v[4];
            int k;
            int mag;
            bit use_c;
            use_c = 0;
`ifdef OPGEN_CORNER_EN
            use_c = n < 4;
`endif
            if (use_c) begin
                for (int i = 0; i < 4; i++)
                    v[i] = n == 0 ? 0 : n == 1 ? MM : n == 2 ? -MM : (i % 2 == 0 ? MM : -MM);
            end else begin
                k = 0;
                while (k < 4) begin
                    mag = int'(ml[16:0]);
                    if (mag <= MM) begin
                        v[k] = ml[17] ? -mag : mag;
                        k++;
                    end
                    ml = step(ml);
                end
            end
            q.push_back({v[0], v[1], v[2], v[3]});
        end
    endtask
    always @(negedge clk) begin
        if (rst) stalled = 0;
        else if (bus.out_valid) begin
            cur = {bus.a, bus.b, bus.c, bus.d};
            if (stalled) check("stall_hold", cur, held);
            if (bus.out_ready) begin
                if (q.size() == 0) check("queue_empty", 1, 0);
                else check("set", cur, q.pop_front());
                check("range", {in_range(bus.a), in_range(bus.b), in_range(bus.c), in_range(bus.d)}, 4'hf);
                got.push_back(cur);
                hs_cnt++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = cur;
            end
        end else stalled = 0;
    end
    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask
    task automatic wait_valid();
        for (int i = 0; i < 500 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("valid_timeout", bus.out_valid, 1);
    endtask
    task automatic wait_done();
        for (int i = 0; i < 5000 && !done; i++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        check("done_timeout", done, 1);
    endtask
    initial begin
        bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus.out_valid, busy, done, vec_cnt}, 0);
        check("rst_ops", {bus.a, bus.b, bus.c, bus.d}, 0);
        rst = 0;
        ml = SEED_V;
        push_run();
        bus.out_ready = 1;
        pulse_start();
        for (int i = 0; i < 500 && hs_cnt < 3; i++) begin
            @(posedge clk); #1;
        end
        check("hs_timeout", hs_cnt >= 3, 1);
        bus.out_ready = 0;
        wait_valid();
        rst = 1;
        #1;
        check("rst_mid_ctrl", {bus.out_valid, busy, done, vec_cnt}, 0);
        check("rst_mid_ops", {bus.a, bus.b, bus.c, bus.d}, 0);
        save_a = got[0];
        q.delete();
        got.delete();
        hs_cnt = 0;
        @(posedge clk); #1 rst = 0;
        ml = SEED_V;
        push_run();
        pulse_start();
        check("busy_run", {busy, done}, 2'b10);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        check("start_in_gen", vec_cnt, 0);
        wait_valid();
        pulse_start();
        check("start_in_offer", {bus.out_valid, vec_cnt}, {1'b1, 7'd0});
        repeat (20) @(posedge clk);
        #1;
        check("stall_valid", bus.out_valid, 1);
        bus.out_ready = 1;
        wait_done();
        check("run_b_hs", hs_cnt, NV);
        check("run_b_cnt", vec_cnt, NV);
        check("run_b_end", {done, busy, bus.out_valid}, 3'b100);
        check("run_b_drained", q.size(), 0);
        check("repro_after_rst", got[0], save_a);
        b_first = got[4];
`ifndef OPGEN_CORNER_EN
        b_first = got[0];
`endif
        got.delete();
        hs_cnt = 0;
        push_run();
        bus.out_ready = 0;
        pulse_start();
        check("restart", {vec_cnt, done, busy}, {7'd0, 1'b0, 1'b1});
        wait_done();
        check("run_c_hs", hs_cnt, NV);
        check("run_c_cnt", vec_cnt, NV);
`ifdef OPGEN_CORNER_EN
        check("run_c_differs", got[4] != b_first, 1);
`else
        check("run_c_differs", got[0] != b_first, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/yadro_operand_gen.md
Name: yadro_operand_gen

Overview:
- Synthesizable operand source that drives the four signed operand inputs (a, b, c, d) of the test_yadro datapath.
- Produces NUM_VECTORS operand sets, each operand drawn from [-MAG_MAX, +MAG_MAX], and offers each set on a valid/ready handshake.
- Sits between the control/CSR side (start/done) and the DUT operand ports; replaces host-side random stimulus so long runs are repeatable from SEED.

Parameters:
- WIDTH, 32, operand width, signed two's complement; must be >= 18.
- NUM_VECTORS, 100, operand sets per run; must be >= 1.
- MAG_MAX, 99999, maximum magnitude; must be < 2^17.
- SEED, 32'h1ACE_B00C, LFSR seed; a value of 0 is replaced by 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse that launches a run; honoured only in IDLE or DONE.
- busy  out  1  high from the cycle after an accepted start until the last set is accepted.
- done  out  1  high in DONE; cleared by the next accepted start.
- out_valid  out  1  operand set valid.
- out_ready  in  1  consumer accepts the set when out_valid && out_ready.
- a, b, c, d  out  WIDTH each  signed operands.
- vec_cnt  out  $clog2(NUM_VECTORS+1)  number of sets accepted in the current run.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, a=b=c=d=0, vec_cnt=0, state=IDLE, LFSR=SEED (or 1 if SEED is 0), op_idx=0. Reset is asynchronous and takes effect mid-operation: no partial set survives and the LFSR reloads SEED.
- LFSR: 32-bit Galois, mask 32'h8020_0003. It steps exactly once per cycle while in GEN and is frozen in every other state.
- FSM states: IDLE, GEN, OFFER, DONE.
- IDLE or DONE + start -> GEN. vec_cnt=0, op_idx=0, done=0, busy=1.
- GEN, each cycle:
  - mag = lfsr[16:0]; sgn = lfsr[17].
  - If mag > MAG_MAX, reject the draw: op_idx unchanged, retry next cycle.
  - Otherwise write operand[op_idx] = sgn ? -mag : +mag, sign-extended to WIDTH, then op_idx++.
  - -0 is emitted as 0.
  - When op_idx 3 is written -> OFFER.
  - Best case is 4 cycles per set; there is no upper bound on retries.
- OFFER: out_valid=1. a..d stay stable until the handshake.
  - On handshake: vec_cnt++, out_valid drops next cycle.
  - If vec_cnt+1 == NUM_VECTORS -> DONE; otherwise -> GEN with op_idx=0.
- out_valid never depends combinationally on out_ready. out_ready held low stalls OFFER indefinitely.
- DONE: done=1, busy=0, out_valid=0; a..d hold the last set.
- start outside IDLE/DONE is ignored. start in DONE begins a new run without reloading the LFSR, so the sequence continues rather than repeats.
- Register order for a..d: a = operand 0, b = 1, c = 2, d = 3.

Optional Feature:
- Macro: OPGEN_CORNER_EN.
- Defined: the first four sets of every run are fixed corners, each taking 4 GEN cycles with the LFSR frozen. Random sets follow, and vec_cnt counts the corner sets toward NUM_VECTORS.
  - Set 0: all 0.
  - Set 1: all +MAG_MAX.
  - Set 2: all -MAG_MAX.
  - Set 3: a=+MAG_MAX, b=-MAG_MAX, c=+MAG_MAX, d=-MAG_MAX.
  - If NUM_VECTORS < 4, only the first NUM_VECTORS corner sets are produced.
- Undefined: all sets are LFSR-derived and no corner logic is present.

Decomposition:
- Package yadro_gen_pkg:
  - state_t enum {IDLE, GEN, OFFER, DONE}.
  - LFSR_MASK = 32'h8020_0003.
  - MAG_BITS = 17.
  - Corner-set index constants.
- Sub-module yadro_lfsr32 holds the Galois LFSR. Ports: clk, rst, en, seed, state; reset loads seed with 0 mapped to 1.
- The FSM, rejection logic and operand registers stay in yadro_operand_gen.

Test Plan:
- Reset mid-OFFER, then release: all outputs 0, state IDLE; a new start reproduces set 0 bit-identical to the first run after power-up.
- start, out_ready tied 1, NUM_VECTORS=100: exactly 100 handshakes, done=1 after the 100th, vec_cnt=100; every operand within [-99999, 99999] and sign-extended over 32 bits.
- out_ready low for 20 cycles during OFFER: out_valid stays 1, a..d unchanged, LFSR frozen (next set identical to the no-stall run).
- Bench golden LFSR model with SEED=1: operand sequence matches bit-exactly, including rejected draws; at least one rejection (mag > 99999) is observed within 100 sets.
- start pulsed in GEN and in OFFER: ignored, vec_cnt unaffected. start in DONE: vec_cnt resets to 0 and the new sets differ from run 1.
- With OPGEN_CORNER_EN, MAG_MAX=99999: sets 0..3 = (0,0,0,0), (99999×4), (-99999×4), (99999,-99999,99999,-99999); set 4 equals set 0 of the non-corner build.
